otter_cu_fsm_mlat: RTL

Multicycle OTTER control-unit FSM with variable memory latency and multi-line interrupts.
- Memory timing: fixed wait-state count via MEM_LATENCY, or a ready handshake (CU_MEM_VALID) when USE_READY=1.
- Interrupts: NUM_IRQ sticky pending lines, fixed priority, gated by CU_MIE.
- Placement: sits between the instruction register/decoder and the datapath (PC, register file, memory, CSR).
- Decoded strobes are asserted only on the cycle a memory phase completes.

---
 rtl/otter_pkg.sv | 50 +++++
 rtl/irq_prio_pending.sv | 46 ++++
 rtl/otter_cu_fsm_mlat.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/otter_pkg.sv
`default_nettype none
// ============================================================================
// Module : otter_pkg
// Opcode, SYSTEM funct3 and FSM state encodings shared by the OTTER CU.
// Rev    : 1.0  initial release
// ============================================================================
package otter_pkg;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011,
    OPC_SYSTEM = 7'b1110011
  } opcode_t;

  typedef enum logic [2:0] {
    F3_PRIV   = 3'b000,
    F3_CSRRW  = 3'b001,
    F3_CSRRS  = 3'b010,
    F3_CSRRC  = 3'b011,
    F3_CSRRWI = 3'b101,
    F3_CSRRSI = 3'b110,
    F3_CSRRCI = 3'b111
  } funct3_system_t;

  localparam logic [11:0] MRET_FUNC12 = 12'h302;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_EXECUTE = 2'd1,
    ST_WB      = 2'd2,
    ST_INTER   = 2'd3
  } cu_state_t;

  function automatic logic is_known_opcode(input logic [6:0] op);
    case (op)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
      OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_SYSTEM: is_known_opcode = 1'b1;
      default:                                               is_known_opcode = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/irq_prio_pending.sv
`default_nettype none
// ============================================================================
// Module : irq_prio_pending
// Sticky interrupt pending register with enable mask and lowest-index priority.
// Rev    : 1.0  initial release
// ============================================================================
module irq_prio_pending
  import otter_pkg::*;
#(
  parameter int NUM_IRQ = 1,
  parameter int IRQW    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] clr,
  input  logic               enable,
  output logic               any_pending,
  output logic [IRQW-1:0]    index
);

  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] masked;

  // Set has priority over clear so a line still asserted during its ack stays pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr) | irq;
    end
  end

  // Requests arriving on the completion cycle are eligible immediately.
  assign masked      = (pending | irq) & {NUM_IRQ{enable}};
  assign any_pending = |masked;

  always_comb begin
    index = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (masked[i]) index = IRQW'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/otter_cu_fsm_mlat.sv
`default_nettype none
// ============================================================================
// Module : otter_cu_fsm_mlat
// Multicycle OTTER control FSM with wait-state/ready memory timing and IRQs.
// Rev    : 1.0  initial release
// ============================================================================
module otter_cu_fsm_mlat
  import otter_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int USE_READY   = 0,
  parameter int NUM_IRQ     = 1,
  parameter int IRQW        = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               CU_CLK,
  input  logic               CU_RESET,
  input  logic [6:0]         CU_OPCODE,
  input  logic [2:0]         CU_FUNC3,
  input  logic [11:0]        CU_FUNC12,
  input  logic [NUM_IRQ-1:0] CU_INT,
  input  logic               CU_MIE,
  input  logic               CU_MEM_VALID,
  output logic               CU_PCWRITE,
  output logic               CU_REGWRITE,
  output logic               CU_MEMWRITE,
  output logic               CU_MEMREAD1,
  output logic               CU_MEMREAD2,
  output logic               CU_csrWrite,
  output logic               CU_mret,
  output logic               CU_intTaken,
  output logic [NUM_IRQ-1:0] CU_intCLR,
  output logic [IRQW-1:0]    CU_intCause,
  output logic               CU_busy
);

  localparam logic [3:0] LAST_CNT = 4'(MEM_LATENCY - 1);

  cu_state_t          state;
  cu_state_t          state_next;
  logic [3:0]         cnt;
  logic               done;
  logic               cnt_run;
  logic               complete;
  logic               is_mret;
  logic               is_csrrw;
  logic               any_pending;
  logic [IRQW-1:0]    pend_index;
  logic [IRQW-1:0]    cause;

  logic               pcwrite;
  logic               regwrite;
  logic               memwrite;
  logic               memread1;
  logic               memread2;
  logic               csr_write;
  logic               mret;
  logic               int_taken;
  logic               busy;
  logic [NUM_IRQ-1:0] int_clr;
  logic [NUM_IRQ-1:0] int_clr_out;

  assign done     = (USE_READY != 0) ? CU_MEM_VALID : (cnt == LAST_CNT);
  assign is_mret  = (CU_OPCODE == OPC_SYSTEM) && (CU_FUNC3 == F3_PRIV) && (CU_FUNC12 == MRET_FUNC12);
  assign is_csrrw = (CU_OPCODE == OPC_SYSTEM) && (CU_FUNC3 == F3_CSRRW);

  irq_prio_pending #(
    .NUM_IRQ (NUM_IRQ),
    .IRQW    (IRQW)
  ) u_irq (
    .clk         (CU_CLK),
    .rst         (CU_RESET),
    .irq         (CU_INT),
    .clr         (int_clr_out),
    .enable      (CU_MIE),
    .any_pending (any_pending),
    .index       (pend_index)
  );

  always_ff @(posedge CU_CLK) begin
    if (CU_RESET) begin
      state <= ST_FETCH;
      cnt   <= '0;
      cause <= '0;
    end else begin
      state <= state_next;
      if (state_next != state) begin
        cnt <= '0;
      end else if (cnt_run) begin
        cnt <= cnt + 4'd1;
      end
      if (complete && any_pending) begin
        cause <= pend_index;
      end
    end
  end

  always_comb begin
    state_next = state;
    cnt_run    = 1'b0;
    complete   = 1'b0;
    pcwrite    = 1'b0;
    regwrite   = 1'b0;
    memwrite   = 1'b0;
    memread1   = 1'b0;
    memread2   = 1'b0;
    csr_write  = 1'b0;
    mret       = 1'b0;
    int_taken  = 1'b0;
    busy       = 1'b0;
    int_clr    = '0;

    case (state)
      ST_FETCH: begin
        memread1 = 1'b1;
        busy     = !done;
        cnt_run  = 1'b1;
        if (done) state_next = ST_EXECUTE;
      end

      ST_EXECUTE: begin
        case (CU_OPCODE)
          OPC_LOAD: begin
            memread2 = 1'b1;
            busy     = !done;
            cnt_run  = 1'b1;
            if (done) state_next = ST_WB;
          end
          OPC_STORE: begin
            memwrite = 1'b1;
            busy     = !done;
            cnt_run  = 1'b1;
            if (done) begin
              pcwrite  = 1'b1;
              complete = 1'b1;
            end
          end
          default: begin
            pcwrite   = 1'b1;
            complete  = 1'b1;
            regwrite  = is_known_opcode(CU_OPCODE) && (CU_OPCODE != OPC_BRANCH) && !is_mret;
            csr_write = is_csrrw;
            mret      = is_mret;
          end
        endcase
      end

      ST_WB: begin
        regwrite = 1'b1;
        pcwrite  = 1'b1;
        complete = 1'b1;
      end

      ST_INTER: begin
        pcwrite    = 1'b1;
        int_taken  = 1'b1;
        state_next = ST_FETCH;
        for (int i = 0; i < NUM_IRQ; i++) begin
          int_clr[i] = (cause == IRQW'(i));
        end
      end

      default: state_next = ST_FETCH;
    endcase

    if (complete) begin
      state_next = any_pending ? ST_INTER : ST_FETCH;
    end
  end

  // Reset blanks every strobe in the same cycle, including mid-phase requests.
  assign int_clr_out = int_clr & {NUM_IRQ{!CU_RESET}};
  assign CU_PCWRITE  = pcwrite   & !CU_RESET;
  assign CU_REGWRITE = regwrite  & !CU_RESET;
  assign CU_MEMWRITE = memwrite  & !CU_RESET;
  assign CU_MEMREAD1 = memread1  & !CU_RESET;
  assign CU_MEMREAD2 = memread2  & !CU_RESET;
  assign CU_csrWrite = csr_write & !CU_RESET;
  assign CU_mret     = mret      & !CU_RESET;
  assign CU_intTaken = int_taken & !CU_RESET;
  assign CU_busy     = busy      & !CU_RESET;
  assign CU_intCLR   = int_clr_out;
  assign CU_intCause = CU_RESET ? '0 : cause;

endmodule
`default_nettype wire
